// File: rtl/oc8051_int_seq_pkg.sv
// oc8051_int_seq_pkg
//   Shared definitions for the interrupt acceptance sequencer:
//   - is_state_e : sequencer state encoding (IDLE, push, vector, pop, return)
//   - VEC_HI_DEF : default upper byte of the vector address
// Configuration macro used by the sequencer: OC8051_INT_WAIT_EN
//   (when defined, one instruction must execute after RETI before a
//   pending interrupt can be vectored).
package oc8051_int_seq_pkg;

  typedef enum logic [2:0] {
    IS_IDLE   = 3'd0,
    IS_PUSH_L = 3'd1,
    IS_PUSH_H = 3'd2,
    IS_VEC    = 3'd3,
    IS_POP_H  = 3'd4,
    IS_POP_L  = 3'd5,
    IS_RET    = 3'd6
  } is_state_e;

  localparam logic [7:0] VEC_HI_DEF = 8'h00;

endpackage

// File: rtl/oc8051_int_seq.sv
// oc8051_int_seq
//   CPU-side interrupt acceptance sequencer. Latches the one-cycle request
//   from the interrupt controller, waits for an instruction boundary, pushes
//   the PC onto the internal-RAM stack (low byte first), loads the vector and
//   acknowledges. On a decoded RETI it pops the PC, restores SP and signals
//   the return back to the controller.
//
// Configuration: define OC8051_INT_WAIT_EN to block a pending interrupt
//   until one instruction boundary has passed after a RETI.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   int_req, int_vec  request pulse and vector low byte from the controller
//   istb, reti_dec    instruction boundary and RETI decode (sampled in IDLE)
//   pc, sp            current PC / SP from the core
//   data_in           RAM read data, valid the cycle after rd
//   busy              core stall, high in every non-IDLE state
//   wr/wr_addr/data_out, rd/rd_addr   internal RAM ports
//   pc_ld/pc_out, sp_ld/sp_out        PC / SP load strobes and values
//   ack, reti         one-cycle handshakes to the controller
//
// Note: the request input is named int_req because "int" is a reserved word.
module oc8051_int_seq
  import oc8051_int_seq_pkg::*;
#(
  parameter logic [7:0] VEC_HI = VEC_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic [7:0]  int_vec,
  input  logic        istb,
  input  logic        reti_dec,
  input  logic [15:0] pc,
  input  logic [7:0]  sp,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic        wr,
  output logic [7:0]  wr_addr,
  output logic [7:0]  data_out,
  output logic        rd,
  output logic [7:0]  rd_addr,
  output logic        pc_ld,
  output logic [15:0] pc_out,
  output logic        sp_ld,
  output logic [7:0]  sp_out,
  output logic        ack,
  output logic        reti
);

  is_state_e  state;
  logic       pend;      // request waiting for acceptance
  logic [7:0] vec_q;     // most recent requested vector
  logic [7:0] act_vec;   // vector of the sequence in flight
  logic       late;      // request arrived during PUSH_L, keep it pending
  logic [7:0] pch;       // popped PC high byte
  logic       blk;       // post-RETI blocker
  logic       pend_any;
  logic       take_int;
  logic       start;

  // A request in the same cycle as istb is already visible.
  assign pend_any = pend | int_req;
  assign take_int = istb & ~reti_dec & pend_any & ~blk;
  assign start    = istb & (reti_dec | (pend_any & ~blk));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IS_IDLE;
      pend    <= 1'b0;
      vec_q   <= 8'h00;
      act_vec <= 8'h00;
      late    <= 1'b0;
      pch     <= 8'h00;
    end else begin
      // Newest request always wins the stored vector (pre-emption).
      if (int_req) begin
        pend  <= 1'b1;
        vec_q <= int_vec;
      end
      case (state)
        IS_IDLE: begin
          if (istb && reti_dec) begin
            state <= IS_POP_H;
          end else if (take_int) begin
            state   <= IS_PUSH_L;
            // Freeze the vector now so later requests cannot alter this ack.
            act_vec <= int_req ? int_vec : vec_q;
            late    <= 1'b0;
          end
        end
        IS_PUSH_L: begin
          state <= IS_PUSH_H;
          if (int_req) late <= 1'b1;
        end
        IS_PUSH_H: begin
          state <= IS_VEC;
          // Clear on VEC entry unless a newer request arrived mid-push.
          if (!int_req) pend <= late;
        end
        IS_VEC:   state <= IS_IDLE;
        IS_POP_H: state <= IS_POP_L;
        IS_POP_L: begin
          pch   <= data_in;
          state <= IS_RET;
        end
        IS_RET:   state <= IS_IDLE;
        default:  state <= IS_IDLE;
      endcase
    end
  end

`ifdef OC8051_INT_WAIT_EN
  // Set when leaving RET; cleared by the next boundary that starts nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk <= 1'b0;
    end else if (state == IS_RET) begin
      blk <= 1'b1;
    end else if (state == IS_IDLE && istb && !start) begin
      blk <= 1'b0;
    end
  end
`else
  assign blk = 1'b0;
`endif

  // Moore decode. RAM reads are synchronous, so in RET data_in carries the
  // low byte read during POP_L while pch holds the high byte from POP_H.
  always_comb begin
    busy     = (state != IS_IDLE);
    wr       = 1'b0;
    wr_addr  = 8'h00;
    data_out = 8'h00;
    rd       = 1'b0;
    rd_addr  = 8'h00;
    pc_ld    = 1'b0;
    pc_out   = 16'h0000;
    sp_ld    = 1'b0;
    sp_out   = 8'h00;
    ack      = 1'b0;
    reti     = 1'b0;
    case (state)
      IS_PUSH_L: begin
        wr       = 1'b1;
        wr_addr  = sp + 8'd1;
        data_out = pc[7:0];
      end
      IS_PUSH_H: begin
        wr       = 1'b1;
        wr_addr  = sp + 8'd2;
        data_out = pc[15:8];
        sp_ld    = 1'b1;
        sp_out   = sp + 8'd2;
      end
      IS_VEC: begin
        pc_ld  = 1'b1;
        pc_out = {VEC_HI, act_vec};
        ack    = 1'b1;
      end
      IS_POP_H: begin
        rd      = 1'b1;
        rd_addr = sp;
      end
      IS_POP_L: begin
        rd      = 1'b1;
        rd_addr = sp - 8'd1;
      end
      IS_RET: begin
        pc_ld  = 1'b1;
        pc_out = {pch, data_in};
        sp_ld  = 1'b1;
        sp_out = sp - 8'd2;
        reti   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
